fine_time_pid: RTL and testbench

Parametrised fine-time particle-ID classifier in the 50 MHz (`clk`) domain. It takes the per-hit time-slice snapshot already moved from the multiphase capture into `clk` and finds the leading edge(s) in the snapshot. It compares the edges against NCLASS programmable window masks and emits one-cycle class pulses, with a programmable dead-time, an optional exclusive-priority mode and per-class hit counters. All of it is configured over the local bus, and it feeds the trigger logic in place of the fixed three-window decode.

---
 rtl/fine_time_pid.sv | 170 +++++++++++++++++
 tb/tb_fine_time_pid.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fine_time_pid.sv
// fine_time_pid: leading-edge finder on a fine-time slice snapshot, classified against NCLASS window masks.
// Define FTPID_HITCNT_EN to build the per-class saturating hit counters (CNT registers).
module fine_time_pid #(
  parameter int         SLICES = 32,
  parameter int         NCLASS = 3,
  parameter logic [7:0] BASE   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLICES-1:0] tl_data,
  input  logic              tl_valid,
  output logic [NCLASS-1:0] class_hit,
  output logic [SLICES-1:0] edge_vec,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  input  logic [7:0]        Address,
  input  logic              Read,
  input  logic              Write
);

  function automatic logic [SLICES-1:0] win_reset(input int idx);
    logic [31:0] val;
    case (idx)
      32'sd0:  val = 32'h0000_00F0;
      32'sd1:  val = 32'h0000_F000;
      32'sd2:  val = 32'h0F00_0000;
      default: val = 32'h0000_0000;
    endcase
    return val[SLICES-1:0];
  endfunction

  logic [NCLASS-1:0] cfg_en_r;
  logic              cfg_excl_r;
  logic [7:0]        cfg_dead_r;
  logic [SLICES-1:0] win_r [NCLASS];
  logic [SLICES-1:0] tl_data_r;
  logic              tl_valid_r;
  logic [1:0]        h_r;
  logic [SLICES-1:0] edge_r;
  logic [NCLASS-1:0] hit_r;
  logic [7:0]        dead_r;
  logic [SLICES+1:0] x_s;
  logic [SLICES-1:0] edge_s;
  logic [NCLASS-1:0] match_s;
  logic [NCLASS-1:0] pick_s;
  logic [NCLASS-1:0] hit_s;
  logic [2:0]        off_s;
  logic              blk_s;
  logic              wr_s;
  logic [31:0]       rd_s;
  logic [31:0]       reg_rd_s [8];
  logic              unused_s;

  assign off_s     = Address[2:0];
  assign blk_s     = (Address[7:3] == BASE[7:3]);
  assign wr_s      = Write & blk_s;
  assign unused_s  = ^DataIn;
  assign class_hit = hit_r;
  assign edge_vec  = edge_r;
  assign DataOut   = rd_s;

  // Bus-writable configuration: CFG word and the window masks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_en_r   <= {NCLASS{1'b0}};
      cfg_excl_r <= 1'b0;
      cfg_dead_r <= 8'h00;
      for (int i = 0; i < NCLASS; i++) win_r[i] <= win_reset(i);
    end else if (wr_s) begin
      if (off_s == 3'd0) begin
        cfg_en_r   <= DataIn[NCLASS-1:0];
        cfg_excl_r <= DataIn[8];
        cfg_dead_r <= DataIn[23:16];
      end else begin
        for (int i = 0; i < NCLASS; i++) begin
          if (int'(off_s) == i + 1) win_r[i] <= DataIn[SLICES-1:0];
          else win_r[i] <= win_r[i];
        end
      end
    end else begin
      cfg_en_r   <= cfg_en_r;
      cfg_excl_r <= cfg_excl_r;
      cfg_dead_r <= cfg_dead_r;
    end
  end

  // Edge pattern: two set slices followed by a clear one; the previous word's top two slices sit below bit 0
  always_comb begin
    x_s    = {tl_data_r, h_r};
    edge_s = {SLICES{1'b0}};
    for (int k = 0; k < SLICES; k++) begin
      edge_s[k] = tl_valid_r & x_s[k] & x_s[k+1] & ~x_s[k+2];
    end
  end

  // Snapshot capture, registered edge vector and carried tail of the last valid word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tl_data_r  <= {SLICES{1'b0}};
      tl_valid_r <= 1'b0;
      h_r        <= 2'b00;
      edge_r     <= {SLICES{1'b0}};
    end else begin
      tl_data_r  <= tl_data;
      tl_valid_r <= tl_valid;
      edge_r     <= edge_s;
      if (tl_valid_r) h_r <= tl_data_r[SLICES-1 -: 2];
      else h_r <= h_r;
    end
  end

  // Window match, optional lowest-index priority, dead-time gating
  always_comb begin
    match_s = {NCLASS{1'b0}};
    for (int i = 0; i < NCLASS; i++) begin
      match_s[i] = (|(edge_r & win_r[i])) & cfg_en_r[i];
    end
    if (cfg_excl_r) pick_s = match_s & (~match_s + NCLASS'(1'b1));
    else pick_s = match_s;
    if (dead_r != 8'd0) hit_s = {NCLASS{1'b0}};
    else hit_s = pick_s;
  end

  // Class pulse register and dead-time countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_r  <= {NCLASS{1'b0}};
      dead_r <= 8'h00;
    end else begin
      hit_r <= hit_s;
      if (dead_r != 8'd0) dead_r <= dead_r - 8'd1;
      else if (|hit_s) dead_r <= cfg_dead_r;
      else dead_r <= dead_r;
    end
  end

`ifdef FTPID_HITCNT_EN
  // With four classes WIN3 owns offset 4, so counters start where the windows end
  localparam int CNT_LO = (NCLASS > 3) ? NCLASS - 3 : 0;
  logic [15:0] cnt_r [NCLASS];

  // Saturating hit counters; a bus write clears and beats a same-edge increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCLASS; i++) cnt_r[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < NCLASS; i++) begin
        if (wr_s && (int'(off_s) == i + 4) && (i >= CNT_LO)) cnt_r[i] <= 16'h0000;
        else if (hit_s[i] && (cnt_r[i] != 16'hFFFF)) cnt_r[i] <= cnt_r[i] + 16'h0001;
        else cnt_r[i] <= cnt_r[i];
      end
    end
  end
`endif

  // Read image per offset; unmapped offsets stay zero, OR-bus idle value is zero
  always_comb begin
    for (int o = 0; o < 8; o++) reg_rd_s[o] = 32'h0000_0000;
    reg_rd_s[0][NCLASS-1:0] = cfg_en_r;
    reg_rd_s[0][8]          = cfg_excl_r;
    reg_rd_s[0][23:16]      = cfg_dead_r;
    for (int i = 0; i < NCLASS; i++) reg_rd_s[i+1][SLICES-1:0] = win_r[i];
`ifdef FTPID_HITCNT_EN
    for (int i = CNT_LO; i < NCLASS; i++) reg_rd_s[i+4][15:0] = cnt_r[i];
`endif
    if (Read && blk_s) rd_s = reg_rd_s[off_s];
    else rd_s = 32'h0000_0000;
  end

endmodule

// File: tb/tb_fine_time_pid.sv
// Self-checking bench for fine_time_pid: vector table, hand sequences and a randomized reference-model run.
module tb_fine_time_pid;
  localparam int         SLICES = 32;
  localparam int         NCLASS = 3;
  localparam logic [7:0] BASE   = 8'h40;
`ifdef FTPID_HITCNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [31:0] ev;
    logic [2:0]  hit;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tl_data;
  logic        tl_valid;
  logic [2:0]  class_hit;
  logic [31:0] edge_vec;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  int          n_pass;
  int          n_total;

  fine_time_pid #(.SLICES(SLICES), .NCLASS(NCLASS), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .tl_data(tl_data), .tl_valid(tl_valid),
    .class_hit(class_hit), .edge_vec(edge_vec), .DataIn(DataIn), .DataOut(DataOut),
    .Address(Address), .Read(Read), .Write(Write)
  );

  initial forever #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    Address = BASE | {5'b00000, off};
    DataIn  = d;
    Write   = 1'b1;
    tick();
    Write   = 1'b0;
    Address = 8'h00;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] d);
    Address = addr;
    Read    = 1'b1;
    #1;
    d       = DataOut;
    Read    = 1'b0;
    Address = 8'h00;
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd(BASE | {5'b00000, off}, v);
    check(name, v, exp);
  endtask

  // one valid word, returns class_hit two edges later, then drains
  task automatic pulse(input logic [31:0] d, output logic [2:0] hit2);
    tl_valid = 1'b1;
    tl_data  = d;
    tick();
    tl_valid = 1'b0;
    tl_data  = 32'h0;
    tick();
    tick();
    hit2 = class_hit;
    repeat (3) tick();
  endtask

  // leading edge = first clear slice after at least two set slices, previous tail below bit 0
  function automatic logic [31:0] ref_edges(input logic [31:0] d, input logic [1:0] h);
    logic [33:0] x;
    logic [33:0] e;
    x = {d, h};
    e = x & (x >> 1) & ~(x >> 2);
    return e[31:0];
  endfunction

  initial begin
    vec_t        tbl [10];
    logic [31:0] v;
    logic [2:0]  h2;
    logic [2:0]  en_m;
    logic        excl_m;
    int          dead_m;
    logic [31:0] win_m [3];
    logic [1:0]  hm;
    int          cnt_m [3];
    logic [31:0] q_e [$];
    logic [2:0]  q_h [$];
    int          last_emit;

    n_pass = 0;
    n_total = 0;
    rst = 1'b0; tl_data = 32'h0; tl_valid = 1'b0; DataIn = 32'h0;
    Address = 8'h00; Read = 1'b0; Write = 1'b0;

    tbl[0] = '{32'h0000_0038, 32'h0000_0040, 3'b001};
    tbl[1] = '{32'h0000_3000, 32'h0000_4000, 3'b010};
    tbl[2] = '{32'h0300_0000, 32'h0400_0000, 3'b100};
    tbl[3] = '{32'h0000_0010, 32'h0000_0000, 3'b000};
    tbl[4] = '{32'h0000_C0C0, 32'h0001_0100, 3'b000};
    tbl[5] = '{32'h0000_6060, 32'h0000_8080, 3'b011};
    tbl[6] = '{32'hC000_0000, 32'h0000_0000, 3'b000};
    tbl[7] = '{32'h0600_0030, 32'h0800_0040, 3'b101};
    tbl[8] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b000};
    tbl[9] = '{32'h0000_0003, 32'h0000_0004, 3'b000};

    repeat (3) tick();
    check("rst_class_hit", 32'(class_hit), 32'h0);
    check("rst_edge_vec", edge_vec, 32'h0);
    rst = 1'b1;
    tick();
    Address = BASE;
    #1;
    check("bus_idle", DataOut, 32'h0);
    Address = 8'h00;
    chk_reg("rst_cfg", 3'd0, 32'h0);
    chk_reg("rst_win0", 3'd1, 32'h0000_00F0);
    chk_reg("rst_win1", 3'd2, 32'h0000_F000);
    chk_reg("rst_win2", 3'd3, 32'h0F00_0000);
    chk_reg("rst_cnt0", 3'd4, 32'h0);
    chk_reg("unmapped7", 3'd7, 32'h0);
    rd(8'h00, v);
    check("other_block", v, 32'h0);

    wr(3'd0, 32'h0000_0007);
    chk_reg("cfg_rb", 3'd0, 32'h0000_0007);

    for (int i = 0; i < 10; i++) begin
      tl_valid = 1'b1;
      tl_data  = 32'h0;
      tick();
      tl_data  = tbl[i].d;
      tick();
      tl_valid = 1'b0;
      tl_data  = 32'h0;
      tick();
      check($sformatf("tbl%0d_edge", i), edge_vec, tbl[i].ev);
      tick();
      check($sformatf("tbl%0d_hit", i), 32'(class_hit), 32'(tbl[i].hit));
      tick();
      check($sformatf("tbl%0d_hit_end", i), 32'(class_hit), 32'h0);
      tick();
    end

    // wrap-around: tail 2'b11 of one word and a clear bit 0 in the next
    wr(3'd1, 32'h0000_0001);
    wr(3'd0, 32'h0000_0001);
    tl_valid = 1'b1; tl_data = 32'hC000_0000; tick();
    tl_data = 32'h0; tick();
    tl_valid = 1'b0; tick();
    check("wrap_hit_first", 32'(class_hit), 32'h0);
    check("wrap_edge", edge_vec, 32'h0000_0001);
    tick();
    check("wrap_hit", 32'(class_hit), 32'h1);
    tick();
    check("wrap_hit_end", 32'(class_hit), 32'h0);
    repeat (2) tick();

    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd0, 32'h0000_0003);
    pulse(32'h0000_000E, h2);
    check("excl_off", 32'(h2), 32'h3);
    wr(3'd0, 32'h0000_0103);
    pulse(32'h0000_000E, h2);
    check("excl_on", 32'(h2), 32'h1);
    wr(3'd0, 32'h0000_0106);
    pulse(32'h0000_000E, h2);
    check("excl_on_c12", 32'(h2), 32'h2);

    wr(3'd1, 32'h0000_00F0);
    wr(3'd2, 32'h0000_F000);
    wr(3'd0, 32'h0003_0001);
    wr(3'd4, 32'h0);
    for (int j = 0; j < 10; j++) begin
      tl_valid = (j < 5);
      tl_data  = 32'h0000_0038;
      tick();
      check($sformatf("dead_hit%0d", j), 32'(class_hit), (j == 2 || j == 6) ? 32'h1 : 32'h0);
    end
    tl_valid = 1'b0;
    chk_reg("dead_cnt0", 3'd4, HAS_CNT ? 32'h2 : 32'h0);

    // counter clear on the same edge as a hit
    wr(3'd0, 32'h0000_0001);
    wr(3'd4, 32'h0);
    tl_valid = 1'b1; tl_data = 32'h0000_0038; tick();
    tl_valid = 1'b0; tick();
    Address = BASE | 8'h04; DataIn = 32'h0000_0055; Write = 1'b1;
    tick();
    Write = 1'b0; Address = 8'h00;
    check("clr_hit", 32'(class_hit), 32'h1);
    chk_reg("clr_wins", 3'd4, 32'h0);
    pulse(32'h0000_0038, h2);
    chk_reg("cnt_after_clr", 3'd4, HAS_CNT ? 32'h1 : 32'h0);

    wr(3'd4, 32'h0); wr(3'd5, 32'h0); wr(3'd6, 32'h0);
    tl_valid = 1'b1; tl_data = 32'h0000_0038;
    repeat (65540) tick();
    tl_valid = 1'b0;
    repeat (4) tick();
    chk_reg("sat_cnt0", 3'd4, HAS_CNT ? 32'h0000_FFFF : 32'h0);
    chk_reg("sat_cnt1", 3'd5, 32'h0);
    pulse(32'h0000_0038, h2);
    chk_reg("sat_hold", 3'd4, HAS_CNT ? 32'h0000_FFFF : 32'h0);
    wr(3'd4, 32'hFFFF_FFFF);
    chk_reg("sat_clr", 3'd4, 32'h0);

    // asynchronous reset with a hit in flight
    tl_valid = 1'b1; tl_data = 32'h0000_0038; tick();
    tl_valid = 1'b0; tick();
    check("pre_rst_edge", edge_vec, 32'h0000_0040);
    #2;
    rst = 1'b0;
    #2;
    check("async_edge", edge_vec, 32'h0);
    check("async_hit", 32'(class_hit), 32'h0);
    chk_reg("async_cfg", 3'd0, 32'h0);
    tick();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("post_rst_hit%0d", j), 32'(class_hit), 32'h0);
    end
    chk_reg("post_rst_win0", 3'd1, 32'h0000_00F0);
    rst = 1'b0; tick();
    rst = 1'b1; tl_valid = 1'b1; tl_data = 32'h0000_0038;
    tick();
    tl_valid = 1'b0;
    tick();
    check("first_after_rel", edge_vec, 32'h0000_0040);

    rst = 1'b0; tick(); rst = 1'b1; tick();
    hm = 2'b00;
    for (int ph = 0; ph < 6; ph++) begin
      en_m   = 3'($urandom_range(0, 7));
      excl_m = 1'($urandom_range(0, 1));
      dead_m = $urandom_range(0, 4);
      for (int i = 0; i < 3; i++) begin
        win_m[i] = (ph % 2 == 1) ? ($urandom | $urandom) : ($urandom & $urandom);
        cnt_m[i] = 0;
      end
      wr(3'd0, {8'h00, 8'(dead_m), 7'h00, excl_m, 5'h00, en_m});
      wr(3'd1, win_m[0]); wr(3'd2, win_m[1]); wr(3'd3, win_m[2]);
      wr(3'd4, 32'h0); wr(3'd5, 32'h0); wr(3'd6, 32'h0);
      repeat (8) tick();
      q_e = '{32'h0};
      q_h = '{3'b000, 3'b000};
      last_emit = -1000;
      for (int t = 0; t < 304; t++) begin
        logic [31:0] d;
        logic        vld;
        logic [31:0] e;
        logic [2:0]  m;
        logic [2:0]  pk;
        logic [2:0]  hh;
        logic [31:0] ones;
        int          mode;
        mode = $urandom_range(0, 2);
        ones = (32'h1 << $urandom_range(1, 6)) - 32'h1;
        if (mode == 0) d = $urandom;
        else if (mode == 1) d = ones << $urandom_range(0, 31);
        else d = $urandom & $urandom;
        vld = (t < 300) && ($urandom_range(0, 3) != 0);
        if (!vld) d = 32'h0;
        e = vld ? ref_edges(d, hm) : 32'h0;
        if (vld) hm = d[31:30];
        m = 3'b000;
        for (int i = 0; i < 3; i++) if (en_m[i] && ((e & win_m[i]) != 32'h0)) m[i] = 1'b1;
        pk = m;
        if (excl_m) for (int i = 2; i >= 0; i--) if (m[i]) pk = 3'b001 << i;
        hh = ((t + 2) - last_emit <= dead_m) ? 3'b000 : pk;
        if (hh != 3'b000) last_emit = t + 2;
        for (int i = 0; i < 3; i++) if (hh[i] && cnt_m[i] < 65535) cnt_m[i]++;
        q_e.push_back(e);
        q_h.push_back(hh);
        tl_valid = vld;
        tl_data  = d;
        tick();
        check($sformatf("rnd%0d_%0d_edge", ph, t), edge_vec, q_e.pop_front());
        check($sformatf("rnd%0d_%0d_hit", ph, t), 32'(class_hit), 32'(q_h.pop_front()));
      end
      tl_valid = 1'b0;
      tl_data  = 32'h0;
      for (int i = 0; i < 3; i++)
        chk_reg($sformatf("rnd%0d_cnt%0d", ph, i), 3'(4 + i), HAS_CNT ? 32'(cnt_m[i]) : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
